msix_msg_gen: RTL and testbench

//  Device-side MSI-X message generator. It is the transmitter for the host interface's MSI-X

---
 rtl/msix_msg_gen_pkg.sv | 19 +
 rtl/msix_msg_gen_rr_arbiter.sv | 26 ++
 rtl/msix_msg_gen.sv | 106 ++++++++++
 tb/tb_msix_msg_gen.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/msix_msg_gen_pkg.sv
// Shared types for the MSI-X message generator: table entry layout and FSM states.
package msix_pkg;

  typedef logic [31:0] U32;
  typedef logic [63:0] U64;

  typedef struct packed {
    U64   addr;
    U32   data;
    logic mask;
  } msix_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    SEND
  } msix_state_e;

endpackage

// File: rtl/msix_msg_gen_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld
);

  always_comb begin
    int unsigned pos;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    pos     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr) + k) % N;
      if (!gnt_vld && req[pos[W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/msix_msg_gen.sv
// MSI-X message generator: vector table, pending bits, round-robin issue of one
// DW memory write per message over a valid/ready channel.
module msix_msg_gen
  import msix_pkg::*;
#(
  parameter int NUM_VEC = 8,
  parameter int VEC_W   = $clog2(NUM_VEC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               msix_en,
  input  logic               func_mask,
  input  logic [NUM_VEC-1:0] intr_req,
  input  logic               tbl_wr_en,
  input  logic [VEC_W-1:0]   tbl_wr_idx,
  input  logic [63:0]        tbl_wr_addr,
  input  logic [31:0]        tbl_wr_data,
  input  logic               tbl_wr_mask,
  output logic               wr_valid,
  input  logic               wr_ready,
  output logic [63:0]        wr_addr,
  output logic [31:0]        wr_data,
  output logic [VEC_W-1:0]   wr_vec,
  output logic [NUM_VEC-1:0] pba,
  output logic               busy
);

  msix_state_e        state, state_nxt;
  msix_entry_t        tbl [NUM_VEC];
  logic [VEC_W-1:0]   ptr;
  logic [NUM_VEC-1:0] mask_vec, set_vec, clr_vec, elig, elig_pre;
  logic               gate;
  logic [VEC_W-1:0]   gnt_idx;
  logic               gnt_vld;

  always_comb begin
    mask_vec = '0;
    for (int unsigned i = 0; i < NUM_VEC; i++) mask_vec[i] = tbl[i].mask;
  end

  assign gate     = msix_en & ~func_mask;
  assign set_vec  = intr_req & {NUM_VEC{msix_en}};
  assign elig     = pba & ~mask_vec & {NUM_VEC{gate}};
  // Leaving IDLE looks at requests landing this cycle so ARB lines up with pba setting.
  assign elig_pre = (pba | set_vec) & ~mask_vec & {NUM_VEC{gate}};

  rr_arbiter #(.N(NUM_VEC), .W(VEC_W)) u_arb (
    .req     (elig),
    .ptr     (ptr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  always_comb begin
    state_nxt = state;
    clr_vec   = '0;
    case (state)
      IDLE: if (|elig_pre) state_nxt = ARB;
      ARB: begin
        if (gnt_vld) begin
          clr_vec[gnt_idx] = 1'b1;
          state_nxt        = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEND: if (wr_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      pba     <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_vec  <= '0;
      for (int unsigned i = 0; i < NUM_VEC; i++) begin
        tbl[i].addr <= '0;
        tbl[i].data <= '0;
        tbl[i].mask <= 1'b1;
      end
    end else begin
      state <= state_nxt;
      // Set wins over the ARB clear so a same-cycle request yields another message.
      pba   <= (pba & ~clr_vec) | set_vec;
      if (tbl_wr_en) begin
        tbl[tbl_wr_idx].addr <= tbl_wr_addr;
        tbl[tbl_wr_idx].data <= tbl_wr_data;
        tbl[tbl_wr_idx].mask <= tbl_wr_mask;
      end
      if (state == ARB && gnt_vld) begin
        wr_addr <= tbl[gnt_idx].addr;
        wr_data <= tbl[gnt_idx].data;
        wr_vec  <= gnt_idx;
        ptr     <= gnt_idx + 1'b1;
      end
    end
  end

  assign wr_valid = (state == SEND);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_msix_msg_gen.sv
// Scoreboard bench for msix_msg_gen: expected writes queued at stimulus, checked at handshake.
module tb_msix_msg_gen;

  logic        clk = 1'b0;
  logic        rst, msix_en, func_mask, tbl_wr_en, tbl_wr_mask, wr_ready;
  logic [7:0]  intr_req;
  logic [2:0]  tbl_wr_idx;
  logic [63:0] tbl_wr_addr;
  logic [31:0] tbl_wr_data;
  logic        wr_valid, busy;
  logic [63:0] wr_addr;
  logic [31:0] wr_data;
  logic [2:0]  wr_vec;
  logic [7:0]  pba;

  typedef struct {
    logic [2:0]  vec;
    logic [63:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   hs_cyc[$];
  int   n_chk = 0, n_fail = 0, cyc = 0, vec1_cnt = 0;

  msix_msg_gen #(.NUM_VEC(8)) dut (
    .clk(clk), .rst(rst), .msix_en(msix_en), .func_mask(func_mask),
    .intr_req(intr_req), .tbl_wr_en(tbl_wr_en), .tbl_wr_idx(tbl_wr_idx),
    .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data), .tbl_wr_mask(tbl_wr_mask),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_vec(wr_vec), .pba(pba), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input int v, input logic [63:0] a, input logic [31:0] d);
    exp_t e;
    e.vec = 3'(v); e.addr = a; e.data = d;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && wr_valid && wr_ready) begin
      hs_cyc.push_back(cyc);
      if (wr_vec == 3'd1) vec1_cnt++;
      if (sb.size() == 0) chk("unexpected_wr", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        chk("wr_vec", 64'(wr_vec), 64'(e.vec));
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] v);
    intr_req = v;
    tick(1);
    intr_req = '0;
  endtask

  task automatic tbl_write(input int idx, input logic [63:0] a, input logic [31:0] d,
                           input logic m);
    tbl_wr_en = 1'b1; tbl_wr_idx = 3'(idx);
    tbl_wr_addr = a; tbl_wr_data = d; tbl_wr_mask = m;
    tick(1);
    tbl_wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((sb.size() != 0 || busy) && k < budget) begin
      tick(1);
      k++;
    end
    chk("idle_reached", 64'(sb.size() == 0 && !busy), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    tick(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    msix_en = 1'b0; func_mask = 1'b0; intr_req = '0; wr_ready = 1'b0;
    tbl_wr_en = 1'b0; tbl_wr_idx = '0; tbl_wr_addr = '0; tbl_wr_data = '0; tbl_wr_mask = 1'b0;
    do_reset();
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_pba", 64'(pba), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_addr", wr_addr, 64'd0);

    // 1) single message latency
    tbl_write(0, 64'h1, 32'h12345678, 1'b0);
    msix_en = 1'b1; wr_ready = 1'b1;
    sb.push_back(mk(0, 64'h1, 32'h12345678));
    pulse(8'h01);
    chk("t1_pba_set", 64'(pba), 64'h01);
    chk("t1_arb_busy", 64'(busy), 64'd1);
    chk("t1_valid_early", 64'(wr_valid), 64'd0);
    tick(1);
    chk("t1_valid_at_2", 64'(wr_valid), 64'd1);
    chk("t1_addr", wr_addr, 64'h1);
    chk("t1_data", 64'(wr_data), 64'h12345678);
    wait_idle(20);

    // 2) masked vector stays pending until unmasked
    tbl_write(2, 64'h2000, 32'h22, 1'b1);
    pulse(8'h04);
    tick(5);
    chk("t2_pba_masked", 64'(pba), 64'h04);
    chk("t2_idle_masked", 64'(busy), 64'd0);
    sb.push_back(mk(2, 64'h2000, 32'h22));
    tbl_write(2, 64'h2000, 32'h22, 1'b0);
    wait_idle(20);
    chk("t2_pba_clear", 64'(pba), 64'h00);

    // 3) all vectors at once, round-robin order and 3-cycle spacing
    do_reset();
    msix_en = 1'b1; wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) tbl_write(i, 64'h1000 + 64'(16 * i), 32'hA0 + 32'(i), 1'b0);
    for (int i = 0; i < 8; i++) sb.push_back(mk(i, 64'h1000 + 64'(16 * i), 32'hA0 + 32'(i)));
    hs_cyc.delete();
    pulse(8'hFF);
    wait_idle(60);
    chk("t3_count", 64'(hs_cyc.size()), 64'd8);
    for (int i = 1; i < hs_cyc.size(); i++) chk("t3_gap", 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd3);
    sb.push_back(mk(0, 64'h1000, 32'hA0));
    sb.push_back(mk(7, 64'h1070, 32'hA7));
    pulse(8'h81);
    wait_idle(30);

    // 4) backpressure holds in-flight message across a table rewrite
    tbl_write(0, 64'h1, 32'h12345678, 1'b0);
    wr_ready = 1'b0;
    sb.push_back(mk(0, 64'h1, 32'h12345678));
    pulse(8'h01);
    tick(1);
    tbl_write(0, 64'h1, 32'h0000DEAD, 1'b0);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 64'(wr_valid), 64'd1);
      chk("t4_hold_data", 64'(wr_data), 64'h12345678);
      tick(1);
    end
    wr_ready = 1'b1;
    wait_idle(20);
    sb.push_back(mk(0, 64'h1, 32'h0000DEAD));
    pulse(8'h01);
    wait_idle(20);

    // 5) re-request during SEND gives a second message
    wr_ready = 1'b0;
    vec1_cnt = 0;
    sb.push_back(mk(1, 64'h1010, 32'hA1));
    sb.push_back(mk(1, 64'h1010, 32'hA1));
    pulse(8'h02);
    tick(1);
    pulse(8'h02);
    tick(2);
    chk("t5_pba_reset", 64'(pba), 64'h02);
    wr_ready = 1'b1;
    wait_idle(40);
    chk("t5_vec1_count", 64'(vec1_cnt), 64'd2);

    // 6) reset during SEND
    wr_ready = 1'b0;
    pulse(8'h08);
    tick(1);
    pulse(8'h30);
    rst = 1'b1;
    sb.delete();
    tick(1);
    rst = 1'b0;
    chk("t6_wr_valid", 64'(wr_valid), 64'd0);
    chk("t6_pba", 64'(pba), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    wr_ready = 1'b1;
    pulse(8'hFF);
    tick(8);
    chk("t6_masks_set_pba", 64'(pba), 64'hFF);
    chk("t6_masks_set_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
